pong_game_ctrl: RTL

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

---
 rtl/pong_game_ctrl_if.sv | 28 ++
 rtl/pong_game_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the Pong game controller and the rest of the game:
// button/frame/miss events in, mode, overlay, score and ball status out.
interface pong_game_ctrl_if;
    logic       start;
    logic       frame_tick;
    logic       miss_p1;
    logic       miss_p2;
    logic [1:0] state;
    logic       motion_en;
    logic       ball_rst;
    logic [1:0] text_sel;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic [1:0] balls_left;
    logic [1:0] winner;

    modport master (
        output start, frame_tick, miss_p1, miss_p2,
        input  state, motion_en, ball_rst, text_sel,
               score_p1, score_p2, balls_left, winner
    );

    modport slave (
        input  start, frame_tick, miss_p1, miss_p2,
        output state, motion_en, ball_rst, text_sel,
               score_p1, score_p2, balls_left, winner
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: title screen, serve delay, rally, game-over hold,
// with BCD scoring, ball counting and winner selection. All outputs registered.
module pong_game_ctrl #(
    parameter int NEWBALL_FRAMES = 120,
    parameter int OVER_FRAMES    = 240,
    parameter int WIN_SCORE      = 7,
    parameter int BALLS          = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    pong_game_ctrl_if.slave   bus
);

    localparam int TMAX = (NEWBALL_FRAMES > OVER_FRAMES) ? NEWBALL_FRAMES : OVER_FRAMES;
    localparam int TW   = ($clog2(TMAX + 1) > 8) ? $clog2(TMAX + 1) : 8;

    localparam logic [TW-1:0] NB_LOAD    = TW'(NEWBALL_FRAMES);
    localparam logic [TW-1:0] OVER_LOAD  = TW'(OVER_FRAMES);
    localparam logic [3:0]    WIN        = 4'(WIN_SCORE);
    localparam logic [1:0]    BALLS_INIT = 2'(BALLS);

    typedef enum logic [1:0] {
        TITLE   = 2'b00,
        NEWBALL = 2'b01,
        PLAY    = 2'b10,
        OVER    = 2'b11
    } state_t;

    state_t        state_q,  state_d;
    logic [TW-1:0] timer,    timer_d;
    logic          start_q;
    logic          motion_en_q, motion_en_d;
    logic          ball_rst_q,  ball_rst_d;
    logic [1:0]    text_sel_q,  text_sel_d;
    logic [3:0]    score_p1_q,  score_p1_d;
    logic [3:0]    score_p2_q,  score_p2_d;
    logic [1:0]    balls_q,     balls_d;
    logic [1:0]    winner_q,    winner_d;
    logic [3:0]    s1_upd, s2_upd;
    logic [1:0]    balls_upd;
    logic          start_rise;
    logic          any_miss;

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s >= 4'd9) ? 4'd9 : s + 4'd1;
    endfunction

    function automatic logic [1:0] floor_dec(input logic [1:0] b);
        return (b == 2'd0) ? 2'd0 : b - 2'd1;
    endfunction

    function automatic logic [1:0] pick_winner(input logic [3:0] s1, input logic [3:0] s2);
        if (s1 > s2)      return 2'b01;
        else if (s2 > s1) return 2'b10;
        else              return 2'b11;
    endfunction

    assign start_rise = bus.start & ~start_q;
    assign any_miss   = bus.miss_p1 | bus.miss_p2;
    assign s1_upd     = bus.miss_p2 ? sat_inc(score_p1_q) : score_p1_q;
    assign s2_upd     = bus.miss_p1 ? sat_inc(score_p2_q) : score_p2_q;
    assign balls_upd  = floor_dec(balls_q);

    always_comb begin
        state_d    = state_q;
        timer_d    = timer;
        score_p1_d = score_p1_q;
        score_p2_d = score_p2_q;
        balls_d    = balls_q;
        winner_d   = winner_q;

        case (state_q)
            TITLE: begin
                score_p1_d = 4'd0;
                score_p2_d = 4'd0;
                balls_d    = BALLS_INIT;
                winner_d   = 2'b00;
                if (start_rise) begin
                    state_d = NEWBALL;
                    timer_d = NB_LOAD;
                end
            end
            NEWBALL: begin
                if (timer == '0)
                    state_d = PLAY;
                else if (bus.frame_tick)
                    timer_d = timer - TW'(1);
            end
            PLAY: begin
                // a miss wins over frame_tick; frame_tick is unused during a rally
                if (any_miss) begin
                    score_p1_d = s1_upd;
                    score_p2_d = s2_upd;
                    balls_d    = balls_upd;
                    if (balls_upd == 2'd0 || s1_upd == WIN || s2_upd == WIN) begin
                        state_d  = OVER;
                        timer_d  = OVER_LOAD;
                        winner_d = pick_winner(s1_upd, s2_upd);
                    end else begin
                        state_d = NEWBALL;
                        timer_d = NB_LOAD;
                    end
                end
            end
            OVER: begin
                if (timer == '0) begin
                    state_d    = TITLE;
                    score_p1_d = 4'd0;
                    score_p2_d = 4'd0;
                    balls_d    = BALLS_INIT;
                    winner_d   = 2'b00;
                end else if (bus.frame_tick) begin
                    timer_d = timer - TW'(1);
                end
            end
            default: state_d = TITLE;
        endcase

        // outputs follow the next state so they line up with the registered state
        ball_rst_d  = (state_d == NEWBALL) && (state_q != NEWBALL);
        motion_en_d = (state_d == PLAY);
        case (state_d)
            TITLE:   text_sel_d = 2'b00;
            OVER:    text_sel_d = 2'b10;
            default: text_sel_d = 2'b01;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= TITLE;
            timer       <= '0;
            start_q     <= 1'b1;
            motion_en_q <= 1'b0;
            ball_rst_q  <= 1'b0;
            text_sel_q  <= 2'b00;
            score_p1_q  <= 4'd0;
            score_p2_q  <= 4'd0;
            balls_q     <= BALLS_INIT;
            winner_q    <= 2'b00;
        end else begin
            state_q     <= state_d;
            timer       <= timer_d;
            start_q     <= bus.start;
            motion_en_q <= motion_en_d;
            ball_rst_q  <= ball_rst_d;
            text_sel_q  <= text_sel_d;
            score_p1_q  <= score_p1_d;
            score_p2_q  <= score_p2_d;
            balls_q     <= balls_d;
            winner_q    <= winner_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.motion_en  = motion_en_q;
    assign bus.ball_rst   = ball_rst_q;
    assign bus.text_sel   = text_sel_q;
    assign bus.score_p1   = score_p1_q;
    assign bus.score_p2   = score_p2_q;
    assign bus.balls_left = balls_q;
    assign bus.winner     = winner_q;

endmodule
